// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one cacheline adaptor between the I-cache and the
// D-cache. One requester is granted at a time. Its address and operation are
// latched, and the adaptor request is held until the line response arrives.
// The response pulse is routed back to the granted requester only.
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ic_address,
  input  logic              ic_read,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic [ADDR_W-1:0] dc_address,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              op_q;
  logic              last_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic serve;

  // Grant decision: a lone requester wins; on a tie D wins unless round-robin
  // is enabled and D was the last one served.
  always_comb begin
    i_req   = ic_read;
    d_req   = dc_read | dc_write;
    grant_d = d_req & (~i_req | (RR_EN == 1'b0) | (last_q == SEL_I));
    grant_i = i_req & ~grant_d;
  end

  // Arbitration FSM: the grant is taken in IDLE, held until mem_resp, and a
  // single RELEASE cycle lets the requester drop its level request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      addr_q <= '0;
      op_q   <= OP_RD;
      last_q <= SEL_D;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state  <= SERVE_D;
            addr_q <= dc_address;
            // A simultaneous read and writeback from D resolves to the writeback.
            op_q   <= dc_write ? OP_WR : OP_RD;
            last_q <= SEL_D;
          end else if (grant_i) begin
            state  <= SERVE_I;
            addr_q <= ic_address;
            op_q   <= OP_RD;
            last_q <= SEL_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) state <= RELEASE;
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Adaptor-side request, driven only from registered state so it is quiet
  // outside SERVE states and zero during reset.
  always_comb begin
    serve       = (state == SERVE_I) || (state == SERVE_D);
    mem_address = serve ? addr_q : '0;
    mem_read    = serve && (op_q == OP_RD);
    mem_write   = serve && (op_q == OP_WR);
    mem_wdata   = (state == SERVE_D) ? dc_wdata : '0;
  end

  // Response routing: the line is broadcast, only the resp pulse qualifies it;
  // a mem_resp outside a SERVE state produces nothing.
  always_comb begin
    ic_resp  = (state == SERVE_I) && mem_resp;
    dc_resp  = (state == SERVE_D) && mem_resp;
    ic_rdata = mem_rdata;
    dc_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a small adaptor model answers requests and a scoreboard of
// expected transactions is checked as requests and responses appear.
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         fp_mode = 1'b0;
  logic [31:0]  ic_address = '0;
  logic         ic_read = 1'b0;
  logic [31:0]  dc_address = '0;
  logic         dc_read = 1'b0;
  logic         dc_write = 1'b0;
  logic [255:0] dc_wdata = '0;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;
  logic         spur = 1'b0;

  logic [255:0] rr_ic_rdata, fp_ic_rdata, rr_dc_rdata, fp_dc_rdata;
  logic [255:0] rr_mem_wdata, fp_mem_wdata;
  logic [31:0]  rr_mem_address, fp_mem_address;
  logic         rr_ic_resp, fp_ic_resp, rr_dc_resp, fp_dc_resp;
  logic         rr_mem_read, fp_mem_read, rr_mem_write, fp_mem_write;

  logic [255:0] ic_rdata, dc_rdata, mem_wdata;
  logic [31:0]  mem_address;
  logic         ic_resp, dc_resp, mem_read, mem_write;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic         is_d;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .ic_address(ic_address), .ic_read(ic_read), .ic_rdata(rr_ic_rdata), .ic_resp(rr_ic_resp),
    .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(rr_dc_rdata), .dc_resp(rr_dc_resp),
    .mem_address(rr_mem_address), .mem_read(rr_mem_read), .mem_write(rr_mem_write),
    .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  cacheline_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .ic_address(ic_address), .ic_read(ic_read), .ic_rdata(fp_ic_rdata), .ic_resp(fp_ic_resp),
    .dc_address(dc_address), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(fp_dc_rdata), .dc_resp(fp_dc_resp),
    .mem_address(fp_mem_address), .mem_read(fp_mem_read), .mem_write(fp_mem_write),
    .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  assign ic_rdata    = fp_mode ? fp_ic_rdata    : rr_ic_rdata;
  assign dc_rdata    = fp_mode ? fp_dc_rdata    : rr_dc_rdata;
  assign ic_resp     = fp_mode ? fp_ic_resp     : rr_ic_resp;
  assign dc_resp     = fp_mode ? fp_dc_resp     : rr_dc_resp;
  assign mem_address = fp_mode ? fp_mem_address : rr_mem_address;
  assign mem_read    = fp_mode ? fp_mem_read    : rr_mem_read;
  assign mem_write   = fp_mode ? fp_mem_write   : rr_mem_write;
  assign mem_wdata   = fp_mode ? fp_mem_wdata   : rr_mem_wdata;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_A5A5}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Adaptor model: answers a held request on its fourth cycle with a 1-cycle
  // resp and an address-derived line; spur injects a stray resp.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        cnt       = 0;
      end else if (spur) begin
        mem_resp  = 1'b1;
        mem_rdata = '1;
        spur      = 1'b0;
      end else if (!reset_n || !(mem_read || mem_write)) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 4) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(mem_address);
        end
      end
    end
  end

  // Scoreboard monitor: every request cycle must match the head transaction,
  // every resp pops it and checks the routing and the line.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_read || mem_write) begin
        if (sb.size() == 0) chk("unexp_mem_req", 1'b1, 1'b0);
        else begin
          chk("mem_addr", mem_address, sb[0].addr);
          chk("mem_op", {mem_read, mem_write}, sb[0].wr ? 2'b01 : 2'b10);
          if (sb[0].wr) chk("mem_wdata", mem_wdata, sb[0].data);
          else if (!sb[0].is_d) chk("mem_wdata_i", mem_wdata, '0);
        end
      end
      if (ic_resp || dc_resp) begin
        if (sb.size() == 0) chk("unexp_resp", {ic_resp, dc_resp}, 2'b00);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_who", {ic_resp, dc_resp}, e.is_d ? 2'b01 : 2'b10);
          if (!e.wr) chk("rdata", e.is_d ? dc_rdata : ic_rdata, e.data);
        end
      end
    end
  end

  task automatic push(input logic is_d, input logic wr, input logic [31:0] addr,
                      input logic [255:0] data);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Waits for the next resp, then steps into the RELEASE cycle.
  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ic_resp || dc_resp) && n < 300);
    if (n >= 300) chk("resp_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_mem_read"}, mem_read, 1'b0);
    chk({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_mem_address"}, mem_address, '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_resp"}, {ic_resp, dc_resp}, 2'b00);
  endtask

  // One isolated transaction from IDLE, with grant latency and RELEASE checks.
  task automatic txn(input logic is_d, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [255:0] data);
    push(is_d, is_d & wr, addr, (is_d & wr) ? data : line_of(addr));
    if (is_d) begin
      dc_address = addr; dc_read = rd; dc_write = wr; dc_wdata = data;
    end else begin
      ic_address = addr; ic_read = 1'b1;
    end
    @(negedge clk);
    chk("grant_cycle_req", {mem_read, mem_write}, 2'b00);
    @(negedge clk);
    chk("grant_plus1_req", mem_read | mem_write, 1'b1);
    wait_resp();
    ic_read = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    @(negedge clk);
    check_quiet("release");
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    chk("reset_ic_rdata", ic_rdata, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: I-only read
    txn(1'b0, 1'b1, 1'b0, 32'h0000_1040, '0);
    // T2: D writeback
    txn(1'b1, 1'b0, 1'b1, 32'h8000_0020, {4{64'hDEAD_BEEF_0123_4567}});
    // D read, then simultaneous read+write resolving to a write
    txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, '0);
    txn(1'b1, 1'b1, 1'b1, 32'h0000_3000, {8{32'h1357_9BDF}});

    // Stray adaptor resp in IDLE must not produce a resp
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spurious_resp", {ic_resp, dc_resp}, 2'b00);
    end
    @(posedge clk);
    #1;

    // T3: simultaneous requests alternate; last grantee is I after T1..? no,
    // D was served last above, so I goes first.
    ic_address = 32'h0000_4400;
    dc_address = 32'h0000_5500;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push(1'b0, 1'b0, 32'h0000_4400, line_of(32'h0000_4400));
      else            push(1'b1, 1'b0, 32'h0000_5500, line_of(32'h0000_5500));
    end
    ic_read = 1'b1; dc_read = 1'b1;
    for (int i = 0; i < 8; i++) wait_resp();
    ic_read = 1'b0; dc_read = 1'b0;
    @(posedge clk);
    #1;

    // T5: D arrives mid SERVE_I and waits
    push(1'b0, 1'b0, 32'h0000_6600, line_of(32'h0000_6600));
    push(1'b1, 1'b0, 32'h0000_7700, line_of(32'h0000_7700));
    ic_address = 32'h0000_6600; ic_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    dc_address = 32'h0000_7700; dc_read = 1'b1;
    wait_resp();
    ic_read = 1'b0;
    wait_resp();
    dc_read = 1'b0;
    @(posedge clk);
    #1;

    // T6: reset mid SERVE_D clears outputs at once
    push(1'b1, 1'b0, 32'h0000_8800, line_of(32'h0000_8800));
    dc_address = 32'h0000_8800; dc_wdata = {8{32'hCAFE_F00D}}; dc_read = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_serving", mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check_quiet("midreset");
    sb.delete();
    dc_read = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    txn(1'b0, 1'b1, 1'b0, 32'h0000_9900, '0);

    // T4: fixed D priority instance
    reset_n = 1'b0;
    fp_mode = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 32'h0000_AA00, line_of(32'h0000_AA00));
    push(1'b0, 1'b0, 32'h0000_BB00, line_of(32'h0000_BB00));
    ic_address = 32'h0000_BB00; dc_address = 32'h0000_AA00;
    ic_read = 1'b1; dc_read = 1'b1;
    for (int i = 0; i < 3; i++) wait_resp();
    dc_read = 1'b0;
    wait_resp();
    ic_read = 1'b0;
    @(posedge clk);
    #1;

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
